mux_rr_n: RTL and testbench

Parametrised N-channel successor to the 2:1 `MuxM` selector. It chooses one of N input channels per cycle and holds the winner in a one-entry registered output stage with a valid/ready handshake. Channel choice is either an externally driven select (fixed mode) or fair round-robin arbitration. It sits between several producers and one shared downstream consumer, replacing combinational 2:1 selection where back-pressure and fairness are needed.

---
 rtl/mux_rr_n.sv | 98 +++++++++
 tb/tb_mux_rr_n.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// N-channel selector with fixed or round-robin channel choice feeding a one-entry
// registered output stage with a valid/ready handshake.
module mux_rr_n #(
    parameter int M  = 4,
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N*(M+1)-1:0]   A,
    input  logic [N-1:0]         AV,
    output logic [N-1:0]         AG,
    input  logic                 MODE,
    input  logic [SW-1:0]        S,
    output logic [M:0]           Y,
    output logic [SW-1:0]        YS,
    output logic                 YV,
    input  logic                 YR
);

    logic [M:0]    r_y;
    logic [SW-1:0] r_ys;
    logic          r_yv;
    logic [SW-1:0] r_p;

    logic          w_le;
    logic [N-1:0]  w_fix_gnt;
    logic [N-1:0]  w_rr_gnt;
    logic          w_found;
    logic [N-1:0]  w_gnt;
    logic          w_xfer;
    logic [SW-1:0] w_k;
    logic [SW-1:0] w_p_next;
    logic [M:0]    w_sel_data;

    // The stage can take a word when empty or when the held word leaves this cycle.
    assign w_le = !r_yv || YR;

    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        w_fix_gnt = '0;
        w_rr_gnt  = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_fix_gnt[i] = AV[i] && (int'(S) == i);
        end
        // Walk offsets from the pointer; exactly one channel matches each offset.
        for (int j = 0; j < N; j++) begin
            for (int c = 0; c < N; c++) begin
                if (!w_found && AV[c] && (((int'(r_p) + j) % N) == c)) begin
                    w_rr_gnt[c] = 1'b1;
                    w_found     = 1'b1;
                end
            end
        end
    end

    assign w_gnt  = (RST || !w_le) ? '0 : (MODE ? w_rr_gnt : w_fix_gnt);
    assign w_xfer = |w_gnt;

    always_comb begin
        w_k        = '0;
        w_p_next   = '0;
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_k        = SW'(i);
                w_p_next   = SW'((i + 1) % N);
                w_sel_data = A[i*(M+1) +: (M+1)];
            end
        end
    end

    // NOTE: all state updates use non-blocking assignments.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_y  <= '0;
            r_ys <= '0;
            r_yv <= 1'b0;
            r_p  <= '0;
        end else if (w_xfer) begin
            r_y  <= w_sel_data;
            r_ys <= w_k;
            r_yv <= 1'b1;
            if (MODE) begin
                r_p <= w_p_next;
            end
        end else if (YR) begin
            r_yv <= 1'b0;
        end
    end

    assign AG = w_gnt;
    assign Y  = r_y;
    assign YS = r_ys;
    assign YV = r_yv;

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed bench for mux_rr_n: reset, round-robin, back-pressure, fixed mode,
// mode switching, sparse wrap and mid-operation reset.
module tb_mux_rr_n;

    localparam int M  = 4;
    localparam int N  = 4;
    localparam int SW = 2;

    logic                CLK;
    logic                RST;
    logic [N*(M+1)-1:0]  A;
    logic [N-1:0]        AV;
    logic [N-1:0]        AG;
    logic                MODE;
    logic [SW-1:0]       S;
    logic [M:0]          Y;
    logic [SW-1:0]       YS;
    logic                YV;
    logic                YR;

    logic [3*(M+1)-1:0]  A3;
    logic [2:0]          AV3;
    logic [2:0]          AG3;
    logic [SW-1:0]       S3;
    logic [M:0]          Y3;
    logic [SW-1:0]       YS3;
    logic                YV3;

    int n_checks = 0;
    int n_errors = 0;

    mux_rr_n #(.M(M), .N(N), .SW(SW)) u_dut (
        .CLK(CLK), .RST(RST), .A(A), .AV(AV), .AG(AG), .MODE(MODE), .S(S),
        .Y(Y), .YS(YS), .YV(YV), .YR(YR)
    );

    mux_rr_n #(.M(M), .N(3), .SW(SW)) u_dut3 (
        .CLK(CLK), .RST(RST), .A(A3), .AV(AV3), .AG(AG3), .MODE(MODE), .S(S3),
        .Y(Y3), .YS(YS3), .YV(YV3), .YR(YR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_data(input logic [M:0] d0, input logic [M:0] d1,
                            input logic [M:0] d2, input logic [M:0] d3);
        A = {d3, d2, d1, d0};
    endtask

    task automatic do_reset();
        RST = 1'b1;
        AV  = '0;
        YR  = 1'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; MODE = 1'b1; S = '0; AV = 4'b1111; YR = 1'b1;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        tick();
        tick();
        n_checks++;
        if (AG !== 4'b0000) begin n_errors++; $display("FAIL rst_ag: got %b exp 0000", AG); end
        n_checks++;
        if (YV !== 1'b0) begin n_errors++; $display("FAIL rst_yv: got %b exp 0", YV); end
        n_checks++;
        if (Y !== 5'h00 || YS !== 2'd0) begin
            n_errors++; $display("FAIL rst_y_ys: got Y=%h YS=%0d exp Y=00 YS=0", Y, YS);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if (AG !== 4'b0001) begin n_errors++; $display("FAIL rel_ag: got %b exp 0001", AG); end
        tick();
        n_checks++;
        if (Y !== 5'h11 || YS !== 2'd0 || YV !== 1'b1) begin
            n_errors++; $display("FAIL rel_out: got Y=%h YS=%0d YV=%b exp Y=11 YS=0 YV=1", Y, YS, YV);
        end
    endtask

    task automatic test_round_robin();
        logic [M:0] exp_y;
        do_reset();
        MODE = 1'b1; AV = 4'b1111; YR = 1'b1;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_y = 5'h11 + 5'(i % 4);
            n_checks++;
            if (YS !== 2'(i % 4) || Y !== exp_y || YV !== 1'b1) begin
                n_errors++;
                $display("FAIL rr_seq[%0d]: got Y=%h YS=%0d YV=%b exp Y=%h YS=%0d YV=1",
                         i, Y, YS, YV, exp_y, i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        MODE = 1'b1; YR = 1'b1; AV = 4'b0100;
        set_data(5'h11, 5'h12, 5'h1A, 5'h14);
        tick();
        n_checks++;
        if (Y !== 5'h1A || YS !== 2'd2 || YV !== 1'b1) begin
            n_errors++; $display("FAIL bp_load: got Y=%h YS=%0d YV=%b exp Y=1a YS=2 YV=1", Y, YS, YV);
        end
        YR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            AV = (i % 2 == 0) ? 4'b1111 : 4'b0000;
            #1;
            n_checks++;
            if (AG !== 4'b0000) begin n_errors++; $display("FAIL bp_ag[%0d]: got %b exp 0000", i, AG); end
            tick();
            n_checks++;
            if (Y !== 5'h1A || YS !== 2'd2 || YV !== 1'b1) begin
                n_errors++;
                $display("FAIL bp_hold[%0d]: got Y=%h YS=%0d YV=%b exp Y=1a YS=2 YV=1", i, Y, YS, YV);
            end
        end
        AV = 4'b1111; YR = 1'b1;
        #1;
        n_checks++;
        if (AG !== 4'b1000) begin n_errors++; $display("FAIL bp_resume_ag: got %b exp 1000", AG); end
        tick();
        n_checks++;
        if (Y !== 5'h14 || YS !== 2'd3 || YV !== 1'b1) begin
            n_errors++; $display("FAIL bp_resume: got Y=%h YS=%0d YV=%b exp Y=14 YS=3 YV=1", Y, YS, YV);
        end
    endtask

    task automatic test_fixed();
        do_reset();
        MODE = 1'b0; S = 2'd3; AV = 4'b1010; YR = 1'b1;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        #1;
        n_checks++;
        if (AG !== 4'b1000) begin n_errors++; $display("FAIL fix_ag: got %b exp 1000", AG); end
        tick();
        n_checks++;
        if (Y !== 5'h14 || YS !== 2'd3 || YV !== 1'b1) begin
            n_errors++; $display("FAIL fix_out: got Y=%h YS=%0d YV=%b exp Y=14 YS=3 YV=1", Y, YS, YV);
        end
        S = 2'd0;
        #1;
        n_checks++;
        if (AG !== 4'b0000) begin n_errors++; $display("FAIL fix_s0_ag: got %b exp 0000", AG); end
        tick();
        n_checks++;
        if (YV !== 1'b0 || Y !== 5'h14 || YS !== 2'd3) begin
            n_errors++; $display("FAIL fix_drain: got Y=%h YS=%0d YV=%b exp Y=14 YS=3 YV=0", Y, YS, YV);
        end
    endtask

    task automatic test_fixed_out_of_range();
        do_reset();
        MODE = 1'b0; YR = 1'b1; S3 = 2'd3; AV3 = 3'b111;
        A3 = {5'h03, 5'h02, 5'h01};
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (AG3 !== 3'b000) begin n_errors++; $display("FAIL n3_ag[%0d]: got %b exp 000", i, AG3); end
            tick();
            n_checks++;
            if (YV3 !== 1'b0) begin n_errors++; $display("FAIL n3_yv[%0d]: got %b exp 0", i, YV3); end
        end
        AV3 = '0;
    endtask

    task automatic test_mode_switch();
        do_reset();
        MODE = 1'b1; YR = 1'b1; AV = 4'b0010;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        tick();
        MODE = 1'b0; S = 2'd0; AV = 4'b1111;
        #1;
        n_checks++;
        if (AG !== 4'b0001) begin n_errors++; $display("FAIL ms_fix_ag: got %b exp 0001", AG); end
        tick();
        n_checks++;
        if (YS !== 2'd0 || Y !== 5'h11) begin
            n_errors++; $display("FAIL ms_fix_out: got Y=%h YS=%0d exp Y=11 YS=0", Y, YS);
        end
        MODE = 1'b1;
        #1;
        n_checks++;
        if (AG !== 4'b0100) begin n_errors++; $display("FAIL ms_rr_resume_ag: got %b exp 0100", AG); end
    endtask

    task automatic test_sparse();
        do_reset();
        MODE = 1'b1; YR = 1'b1; AV = 4'b0100;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        #1;
        n_checks++;
        if (AG !== 4'b0100) begin n_errors++; $display("FAIL sp_ag0: got %b exp 0100", AG); end
        tick();
        AV = 4'b0101;
        #1;
        n_checks++;
        if (AG !== 4'b0001) begin n_errors++; $display("FAIL sp_ag_wrap: got %b exp 0001", AG); end
        tick();
        n_checks++;
        if (YS !== 2'd0 || Y !== 5'h11) begin
            n_errors++; $display("FAIL sp_out_wrap: got Y=%h YS=%0d exp Y=11 YS=0", Y, YS);
        end
        #1;
        n_checks++;
        if (AG !== 4'b0100) begin n_errors++; $display("FAIL sp_ag2: got %b exp 0100", AG); end
        tick();
        n_checks++;
        if (YS !== 2'd2 || Y !== 5'h13) begin
            n_errors++; $display("FAIL sp_out2: got Y=%h YS=%0d exp Y=13 YS=2", Y, YS);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        MODE = 1'b1; YR = 1'b1; AV = 4'b0010;
        set_data(5'h11, 5'h12, 5'h13, 5'h14);
        tick();
        YR = 1'b0;
        tick();
        n_checks++;
        if (YV !== 1'b1 || YS !== 2'd1) begin
            n_errors++; $display("FAIL mr_held: got YV=%b YS=%0d exp YV=1 YS=1", YV, YS);
        end
        RST = 1'b1; AV = 4'b1111;
        #1;
        n_checks++;
        if (AG !== 4'b0000) begin n_errors++; $display("FAIL mr_rst_ag: got %b exp 0000", AG); end
        tick();
        RST = 1'b0;
        n_checks++;
        if (YV !== 1'b0 || Y !== 5'h00 || YS !== 2'd0) begin
            n_errors++; $display("FAIL mr_cleared: got Y=%h YS=%0d YV=%b exp Y=00 YS=0 YV=0", Y, YS, YV);
        end
        YR = 1'b1;
        #1;
        n_checks++;
        if (AG !== 4'b0001) begin n_errors++; $display("FAIL mr_rearb_ag: got %b exp 0001", AG); end
        tick();
        n_checks++;
        if (YS !== 2'd0 || Y !== 5'h11 || YV !== 1'b1) begin
            n_errors++; $display("FAIL mr_rearb_out: got Y=%h YS=%0d YV=%b exp Y=11 YS=0 YV=1", Y, YS, YV);
        end
    endtask

    initial begin
        RST = 1'b1; A = '0; AV = '0; MODE = 1'b0; S = '0; YR = 1'b0;
        A3 = '0; AV3 = '0; S3 = '0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_fixed();
        test_fixed_out_of_range();
        test_mode_switch();
        test_sparse();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
